// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: pixel-enable divider, H/V timing, integer-upscaled two-page
// framebuffer addressing and a one-pixel registered output stage with border colour.
module vga_scan_ctrl #(
  parameter int CLK_DIV         = 2,
  parameter int RD_LATENCY      = 1,
  parameter int COLOR_BITS      = 1,
  parameter int H_VISIBLE       = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int FB_WIDTH        = 214,
  parameter int FB_HEIGHT       = 160,
  parameter int SCALE           = 3,
  parameter int A_WIDTH         = 17
) (
  input  logic                    clk,
  input  logic                    n_rst_async,
  input  logic                    fb_page,
  input  logic [3*COLOR_BITS-1:0] border_color,
  output logic [A_WIDTH-1:0]      fb_addr,
  input  logic [3*COLOR_BITS-1:0] fb_pixel,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    page_active,
  output logic                    vblank,
  output logic                    vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int PW      = 3 * COLOR_BITS;
  localparam int H_AREA  = (FB_WIDTH * SCALE < H_VISIBLE) ? FB_WIDTH * SCALE : H_VISIBLE;
  localparam int V_AREA  = (FB_HEIGHT * SCALE < V_VISIBLE) ? FB_HEIGHT * SCALE : V_VISIBLE;
  localparam logic [A_WIDTH-1:0] PAGE_SIZE = A_WIDTH'(FB_WIDTH * FB_HEIGHT);
  localparam logic [A_WIDTH-1:0] LINE_STEP = A_WIDTH'(FB_WIDTH);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  if (CLK_DIV < 2) begin : g_chkDiv
    $error("vga_scan_ctrl: CLK_DIV must be at least 2");
  end
  if (RD_LATENCY > CLK_DIV - 1) begin : g_chkLat
    $error("vga_scan_ctrl: RD_LATENCY must not exceed CLK_DIV-1");
  end
  if (2 * FB_WIDTH * FB_HEIGHT > (2 ** A_WIDTH)) begin : g_chkAddr
    $error("vga_scan_ctrl: A_WIDTH too small for two framebuffer pages");
  end

  logic [DW-1:0]      r_divCnt;
  logic [HW-1:0]      r_hCnt, w_hNxt, r_fbX, w_fbXNxt;
  logic [VW-1:0]      r_vCnt, w_vNxt;
  logic [SW-1:0]      r_xSub, w_xSubNxt, r_ySub, w_ySubNxt;
  logic [A_WIDTH-1:0] r_lineBase, w_lineBaseNxt, r_fbAddr;
  logic [PW-1:0]      r_rgb;
  logic               r_pageActive, r_vblank, r_vblankStart, r_hsync, r_vsync;
  logic               w_pixEn, w_hWrap, w_vWrap, w_xWrap, w_yWrap;
  logic               w_visible, w_area, w_hsWin, w_vsWin, w_vbEnter;

  assign w_pixEn   = (r_divCnt == DW'(CLK_DIV - 1));
  assign w_hWrap   = (r_hCnt == HW'(H_TOTAL - 1));
  assign w_vWrap   = (r_vCnt == VW'(V_TOTAL - 1));
  assign w_xWrap   = (r_xSub == SW'(SCALE - 1));
  assign w_yWrap   = (r_ySub == SW'(SCALE - 1));
  assign w_visible = (r_hCnt < HW'(H_VISIBLE)) && (r_vCnt < VW'(V_VISIBLE));
  assign w_area    = (r_hCnt < HW'(H_AREA)) && (r_vCnt < VW'(V_AREA));
  assign w_hsWin   = (r_hCnt >= HW'(H_VISIBLE + H_FP)) && (r_hCnt < HW'(H_VISIBLE + H_FP + H_SYNC));
  assign w_vsWin   = (r_vCnt >= VW'(V_VISIBLE + V_FP)) && (r_vCnt < VW'(V_VISIBLE + V_FP + V_SYNC));
  assign w_vbEnter = w_hWrap && (r_vCnt == VW'(V_VISIBLE - 1));

  // Next scan position; the line base carries page offset plus fb_y*FB_WIDTH so no multiplier is needed
  always_comb begin
    w_hNxt        = r_hCnt;
    w_vNxt        = r_vCnt;
    w_xSubNxt     = r_xSub;
    w_ySubNxt     = r_ySub;
    w_fbXNxt      = r_fbX;
    w_lineBaseNxt = r_lineBase;
    if (w_hWrap) begin
      w_hNxt    = '0;
      w_xSubNxt = '0;
      w_fbXNxt  = '0;
      if (w_vWrap) begin
        w_vNxt        = '0;
        w_ySubNxt     = '0;
        w_lineBaseNxt = r_pageActive ? PAGE_SIZE : '0;
      end else begin
        w_vNxt = r_vCnt + 1'b1;
        if (w_yWrap) begin
          w_ySubNxt     = '0;
          w_lineBaseNxt = r_lineBase + LINE_STEP;
        end else begin
          w_ySubNxt = r_ySub + 1'b1;
        end
      end
    end else begin
      w_hNxt = r_hCnt + 1'b1;
      if (w_xWrap) begin
        w_xSubNxt = '0;
        w_fbXNxt  = r_fbX + 1'b1;
      end else begin
        w_xSubNxt = r_xSub + 1'b1;
      end
    end
  end

  // Address tracks the held (h,v); colour and syncs for that pixel are registered at the end of its period
  always_ff @(posedge clk or negedge n_rst_async) begin
    if (!n_rst_async) begin
      r_divCnt      <= '0;
      r_hCnt        <= '0;
      r_vCnt        <= '0;
      r_xSub        <= '0;
      r_ySub        <= '0;
      r_fbX         <= '0;
      r_lineBase    <= '0;
      r_fbAddr      <= '0;
      r_pageActive  <= 1'b0;
      r_vblank      <= 1'b0;
      r_vblankStart <= 1'b0;
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_rgb         <= '0;
    end else begin
      r_vblankStart <= 1'b0;
      r_divCnt      <= w_pixEn ? '0 : r_divCnt + 1'b1;
      if (w_pixEn) begin
        r_hCnt     <= w_hNxt;
        r_vCnt     <= w_vNxt;
        r_xSub     <= w_xSubNxt;
        r_ySub     <= w_ySubNxt;
        r_fbX      <= w_fbXNxt;
        r_lineBase <= w_lineBaseNxt;
        r_fbAddr   <= w_lineBaseNxt + A_WIDTH'(w_fbXNxt);
        r_vblank   <= (w_vNxt >= VW'(V_VISIBLE));
        if (w_vbEnter) begin
          r_pageActive  <= fb_page;
          r_vblankStart <= 1'b1;
        end
        r_hsync <= w_hsWin ? ~SYNC_IDLE : SYNC_IDLE;
        r_vsync <= w_vsWin ? ~SYNC_IDLE : SYNC_IDLE;
        r_rgb   <= w_area ? fb_pixel : (w_visible ? border_color : '0);
      end
    end
  end

  assign fb_addr      = r_fbAddr;
  assign vga_r        = r_rgb[PW-1 -: COLOR_BITS];
  assign vga_g        = r_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
  assign vga_b        = r_rgb[COLOR_BITS-1:0];
  assign vga_hsync    = r_hsync;
  assign vga_vsync    = r_vsync;
  assign page_active  = r_pageActive;
  assign vblank       = r_vblank;
  assign vblank_start = r_vblankStart;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl on a small timing set: a pixel-index model predicts
// every output pixel from the timing rules, and a monitor pops and compares each pixel period.
module tb_vga_scan_ctrl;

  localparam int CLK_DIV = 3, RD_LATENCY = 2, COLOR_BITS = 2;
  localparam int H_VISIBLE = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_VISIBLE = 12, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int FB_WIDTH = 7, FB_HEIGHT = 3, SCALE = 3, A_WIDTH = 6;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;
  localparam int PW = 3 * COLOR_BITS;
  localparam int FBSZ = FB_WIDTH * FB_HEIGHT;

  typedef struct {
    int            pix;
    logic [PW-1:0] rgb;
    logic          hs, vs, vb, vbs, pg, addrOk;
    int            addr;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  n_rst;
  logic                  fb_page;
  logic [PW-1:0]         border_color;
  logic [A_WIDTH-1:0]    fb_addr;
  logic [PW-1:0]         fb_pixel;
  logic [COLOR_BITS-1:0] vga_r, vga_g, vga_b;
  logic                  vga_hsync, vga_vsync, page_active, vblank, vblank_start;

  logic [PW-1:0] rdPipe [RD_LATENCY];
  exp_t          expQ [$];
  int            checks = 0;
  int            failures = 0;
  int            clkCount = 0;
  logic          modelPage = 1'b0;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .RD_LATENCY(RD_LATENCY), .COLOR_BITS(COLOR_BITS),
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_ACTIVE_LOW(1), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT),
    .SCALE(SCALE), .A_WIDTH(A_WIDTH)
  ) dut (
    .clk(clk), .n_rst_async(n_rst), .fb_page(fb_page), .border_color(border_color),
    .fb_addr(fb_addr), .fb_pixel(fb_pixel), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .page_active(page_active),
    .vblank(vblank), .vblank_start(vblank_start)
  );

  function automatic logic [PW-1:0] sramData(int a);
    return PW'(a * 37 + 11);
  endfunction

  // SRAM read port: data for an address appears RD_LATENCY clocks later
  always @(posedge clk) begin
    rdPipe[0] <= sramData(int'(fb_addr));
    for (int i = 1; i < RD_LATENCY; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign fb_pixel = rdPipe[RD_LATENCY-1];

  task automatic checkOutput(string name, int got, int want, int tag);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s pix=%0d got=%0h expected=%0h", name, tag, got, want);
    end
  endtask

  // Reference model: pixel p occupies clocks [p*CLK_DIV, (p+1)*CLK_DIV) after release
  always @(posedge clk) begin : modelStep
    int p, h, v, h1, v1;
    bit vis, area;
    exp_t e;
    if (!n_rst) begin
      clkCount = 0;
      modelPage = 1'b0;
    end else begin
      clkCount++;
      if (clkCount % CLK_DIV == 0) begin
        p    = clkCount / CLK_DIV - 1;
        h    = p % H_TOTAL;
        v    = (p / H_TOTAL) % V_TOTAL;
        vis  = (h < H_VISIBLE) && (v < V_VISIBLE);
        area = vis && (h < FB_WIDTH * SCALE) && (v < FB_HEIGHT * SCALE);
        e.pix = p;
        e.rgb = area ? sramData(int'(modelPage) * FBSZ + (v / SCALE) * FB_WIDTH + h / SCALE)
                     : (vis ? border_color : '0);
        e.hs  = !((h >= H_VISIBLE + H_FP) && (h < H_VISIBLE + H_FP + H_SYNC));
        e.vs  = !((v >= V_VISIBLE + V_FP) && (v < V_VISIBLE + V_FP + V_SYNC));
        if (h == H_TOTAL - 1 && v == V_VISIBLE - 1) modelPage = fb_page;
        h1 = (p + 1) % H_TOTAL;
        v1 = ((p + 1) / H_TOTAL) % V_TOTAL;
        e.vb     = (v1 >= V_VISIBLE);
        e.vbs    = (h1 == 0) && (v1 == V_VISIBLE);
        e.pg     = modelPage;
        e.addrOk = (h1 < H_VISIBLE) && (h1 < FB_WIDTH * SCALE) &&
                   (v1 < V_VISIBLE) && (v1 < FB_HEIGHT * SCALE);
        e.addr   = int'(modelPage) * FBSZ + (v1 / SCALE) * FB_WIDTH + h1 / SCALE;
        expQ.push_back(e);
      end
    end
  end

  // Monitor: one expected entry per pixel period, vblank_start must idle low in between
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!n_rst) begin
      expQ.delete();
    end else if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rgb", int'({vga_r, vga_g, vga_b}), int'(e.rgb), e.pix);
      checkOutput("hsync", int'(vga_hsync), int'(e.hs), e.pix);
      checkOutput("vsync", int'(vga_vsync), int'(e.vs), e.pix);
      checkOutput("vblank", int'(vblank), int'(e.vb), e.pix);
      checkOutput("vblank_start", int'(vblank_start), int'(e.vbs), e.pix);
      checkOutput("page_active", int'(page_active), int'(e.pg), e.pix);
      if (e.addrOk) checkOutput("fb_addr", int'(fb_addr), e.addr, e.pix + 1);
    end else begin
      checkOutput("vblank_start_idle", int'(vblank_start), 0, -1);
    end
  end

  // Random page requests and border colours, changed only on falling edges
  initial begin
    fb_page = 1'b0;
    forever begin
      repeat ($urandom_range(1, 300)) @(negedge clk);
      fb_page = ~fb_page;
    end
  end

  initial begin
    border_color = PW'($urandom);
    forever begin
      repeat ($urandom_range(50, 400)) @(negedge clk);
      border_color = PW'($urandom);
    end
  end

  // Hold reset, check the idle outputs, release and time the first hsync fall
  task automatic applyStimulus(int holdCycles);
    int cnt;
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1;
    checkOutput("rst_rgb", int'({vga_r, vga_g, vga_b}), 0, -1);
    checkOutput("rst_hsync", int'(vga_hsync), 1, -1);
    checkOutput("rst_vsync", int'(vga_vsync), 1, -1);
    checkOutput("rst_fb_addr", int'(fb_addr), 0, -1);
    checkOutput("rst_page", int'(page_active), 0, -1);
    checkOutput("rst_vblank", int'(vblank), 0, -1);
    checkOutput("rst_vblank_start", int'(vblank_start), 0, -1);
    repeat (holdCycles) @(negedge clk);
    checkOutput("rst_hold_fb_addr", int'(fb_addr), 0, -1);
    checkOutput("rst_hold_hsync", int'(vga_hsync), 1, -1);
    #1 n_rst = 1'b1;
    cnt = 0;
    while (cnt < 2 * H_TOTAL * CLK_DIV) begin
      @(posedge clk);
      cnt++;
      #1;
      if (!vga_hsync) break;
    end
    checkOutput("first_hsync_fall_clk", cnt, (H_VISIBLE + H_FP + 1) * CLK_DIV, -1);
  endtask

  initial begin
    n_rst = 1'b0;
    $display("[TB] vga_scan_ctrl scoreboard run, frame = %0d clocks", FRAME_CLKS);
    applyStimulus(4);
    repeat (3 * FRAME_CLKS + $urandom_range(0, FRAME_CLKS - 1)) @(posedge clk);
    applyStimulus(5);
    repeat (3 * FRAME_CLKS) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Parametrised successor of the current fixed 640x480, 3-bit VGA output controller.
- Generates VGA timing from a configurable timing set and derives a pixel enable from the system clock.
- Scans an integer-upscaled framebuffer with two pages: a page select is latched once per frame at vblank start. Outside the scaled framebuffer area it emits a border colour.
- Sits between the framebuffer SRAM read port and the VGA pins; the rasterizer/CPU uses its page and vblank outputs to swap buffers tear-free.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz pixel); must be >= 2.
- RD_LATENCY, 1, framebuffer read latency in clocks; elaboration error unless RD_LATENCY <= CLK_DIV-1.
- COLOR_BITS, 1, bits per colour channel; a pixel is 3*COLOR_BITS wide, ordered {r,g,b}.
- H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
- V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
- SYNC_ACTIVE_LOW, 1, sync polarity.
- FB_WIDTH, 214, framebuffer width.
- FB_HEIGHT, 160, framebuffer height.
- SCALE, 3, integer upscale factor applied in both axes.
- A_WIDTH, 17, framebuffer address width; must hold 2*FB_WIDTH*FB_HEIGHT.

Ports:
- clk  in  1  system clock
- n_rst_async  in  1  asynchronous active-low reset
- fb_page  in  1  requested display page, sampled only at vblank start
- border_color  in  3*COLOR_BITS  colour outside the framebuffer area
- fb_addr  out  A_WIDTH  framebuffer read address
- fb_pixel  in  3*COLOR_BITS  read data, valid RD_LATENCY clocks after fb_addr
- vga_r, vga_g, vga_b  out  COLOR_BITS each  colour outputs
- vga_hsync, vga_vsync  out  1  sync outputs
- page_active  out  1  page currently being scanned
- vblank  out  1  high while v_cnt >= V_VISIBLE
- vblank_start  out  1  one-clock pulse when vblank begins

Behaviour:
- Reset (async assert, clocked release):
  - div_cnt, h_cnt, v_cnt, sub-counters, fb_addr, page_active = 0.
  - RGB = 0.
  - Syncs inactive (high when SYNC_ACTIVE_LOW).
  - vblank = 0, vblank_start = 0.
  - Reset mid-frame restarts scan at (0,0) on page 0.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div_cnt == CLK_DIV-1); all scan state advances only on pix_en.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of the H params).
  - On h_cnt wrap, v_cnt advances 0..V_TOTAL-1 and wraps.
- Framebuffer coordinates (no dividers):
  - x_sub counts 0..SCALE-1; fb_x increments when x_sub wraps; both clear at h_cnt = 0.
  - y_sub/fb_y behave the same per line; both clear at v_cnt = 0.
- fb_area = (h_cnt < FB_WIDTH*SCALE) && (h_cnt < H_VISIBLE) && (v_cnt < FB_HEIGHT*SCALE) && (v_cnt < V_VISIBLE).
- Address:
  - On each pix_en, fb_addr <= page_active*FB_WIDTH*FB_HEIGHT + fb_y*FB_WIDTH + fb_x for the current (h,v).
  - Maintained incrementally (line-base register plus fb_x); a held value is allowed outside fb_area.
- Output stage:
  - On the next pix_en, RGB <= fb_pixel if the pixel's delayed fb_area is set; border_color if visible but not fb_area; 0 if not visible.
  - hsync/vsync go through the same one-pixel delay, so sync and colour stay aligned. Total latency is one pixel period (CLK_DIV clocks).
- Sync windows:
  - hsync is active for H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC.
  - vsync is active for V_VISIBLE+V_FP <= v_cnt < ... + V_SYNC.
- Page swap:
  - On the pix_en where (h_cnt,v_cnt) becomes (0,V_VISIBLE), page_active <= fb_page and vblank_start pulses for exactly one clk. vblank rises in the same cycle.
  - fb_page changes at any other time have no effect until the next vblank start.
- Non-multiple sizes:
  - With defaults, FB_WIDTH*SCALE = 642 > 640; columns 640/641 are never displayed and fb_x = 213 shows one column.
  - When FB_HEIGHT*SCALE < V_VISIBLE, remaining visible lines show border_color.

Test Plan:
- Release reset, run one frame: first sync edges at clk 2*(656+1); hsync low for 192 clks every 1600 clks; vsync low for 2 lines starting at line 490; frame period 840000 clks.
- During reset: outputs RGB = 0, hsync = vsync = 1, fb_addr = 0. Assert reset mid-line at h = 300; after release, counters restart and next hsync falls at clk 1314 after release.
- SRAM model returns addr[2:0]: line 0 pixels h = 0,1,2 map to fb_addr 0; h = 3..5 map to 1; h = 639 maps to addr 213; lines 3..5 start at 214; RGB matches, delayed one pixel from counters.
- SCALE = 2 with FB_HEIGHT = 160 (320 lines): visible lines 320..479 and columns 428..639 output border_color = 3'b101; blanking outputs 0.
- Toggle fb_page at line 100 and 479: page_active changes only at (0,480); vblank_start high exactly 1 clk; next frame's line 0 fb_addr = 34240.
- COLOR_BITS = 4, CLK_DIV = 4, RD_LATENCY = 3: data/addr alignment holds; 12-bit pixel split r = [11:8], g = [7:4], b = [3:0].
